// File: rtl/core_pkg.sv
// Core-wide shared types: RV32 major opcodes plus the branch target buffer
// entry layout, sweep FSM states and counter constants.
// BTB_HYST_EN selects a 2-bit hysteresis counter; otherwise 1 bit.
package core_pkg;

    // RV32I major opcodes (instr[6:0])
    typedef enum logic [6:0] {
        OPCODE_LOAD   = 7'h03,
        OPCODE_OP_IMM = 7'h13,
        OPCODE_AUIPC  = 7'h17,
        OPCODE_STORE  = 7'h23,
        OPCODE_OP     = 7'h33,
        OPCODE_LUI    = 7'h37,
        OPCODE_BRANCH = 7'h63,
        OPCODE_JUMP_R = 7'h67,
        OPCODE_JUMP   = 7'h6f,
        OPCODE_SYSTEM = 7'h73
    } rv32_opcodes_e;

    // Default table depth and its index width
    localparam int BTB_ENTRIES   = 32;
    localparam int BTB_IDX_W     = $clog2(BTB_ENTRIES);
    // Smallest legal table (4 entries) has the widest tag; the stored tag
    // field is sized for it so any legal depth fits, upper bits zero.
    localparam int BTB_MIN_IDX_W = 2;
    localparam int BTB_TAG_W     = 30 - BTB_MIN_IDX_W;

    localparam logic [1:0] CTR_WEAK_T   = 2'b10;
    localparam logic [1:0] CTR_STRONG_T = 2'b11;

`ifdef BTB_HYST_EN
    localparam int BTB_CTR_W = 2;
    localparam logic [BTB_CTR_W-1:0] BTB_CTR_ALLOC = CTR_WEAK_T;
    localparam logic [BTB_CTR_W-1:0] BTB_CTR_JUMP  = CTR_STRONG_T;
`else
    localparam int BTB_CTR_W = 1;
    localparam logic [BTB_CTR_W-1:0] BTB_CTR_ALLOC = 1'b1;
    localparam logic [BTB_CTR_W-1:0] BTB_CTR_JUMP  = 1'b1;
`endif

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [30:0]          target;
        logic [BTB_CTR_W-1:0] ctr;
    } btb_entry_t;

    typedef enum logic {
        BTB_IDLE  = 1'b0,
        BTB_SWEEP = 1'b1
    } btb_state_e;

endpackage

// File: rtl/btb_sat_counter.sv
// Next-state of the BTB direction counter from {ctr, taken}.
// BTB_HYST_EN: 2-bit saturating up/down counter; otherwise the 1-bit
// counter simply records the last outcome.
module btb_sat_counter
    import core_pkg::*;
(
    input  logic [BTB_CTR_W-1:0] i_ctr,
    input  logic                 i_taken,
    output logic [BTB_CTR_W-1:0] o_ctr
);

`ifdef BTB_HYST_EN
    // Saturating increment on taken, decrement on not-taken
    always_comb begin
        o_ctr = i_ctr;
        if (i_taken) begin
            if (i_ctr != CTR_STRONG_T) o_ctr = i_ctr + 1'b1;
        end else begin
            if (i_ctr != 2'b00) o_ctr = i_ctr - 1'b1;
        end
    end
`else
    logic w_unused_ctr;
    assign w_unused_ctr = ^i_ctr;
    assign o_ctr        = i_taken;
`endif

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer. Lookups return a registered
// prediction one cycle after the request; execute updates the table with
// resolved outcomes; flush_i starts a one-entry-per-cycle invalidate sweep.
// BTB_HYST_EN selects the 2-bit direction counter (see btb_sat_counter).
module branch_target_buffer
    import core_pkg::*;
#(
    parameter  int ENTRIES = BTB_ENTRIES,
    localparam int IDX_W   = $clog2(ENTRIES),
    localparam int TAG_W   = 30 - IDX_W
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          fetch_req_i,
    input  logic [31:0]   fetch_pc_i,
    output logic          pred_valid_o,
    output logic          pred_taken_o,
    output logic [31:0]   pred_target_o,
    input  logic          upd_valid_i,
    input  logic [31:0]   upd_pc_i,
    input  logic [31:0]   upd_target_i,
    input  logic          upd_taken_i,
    input  rv32_opcodes_e upd_opcode_i,
    input  logic          flush_i,
    output logic          busy_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    // Tag/target/ctr storage; valid bits live in r_valid so reset and the
    // sweep can clear them without touching the data array.
    btb_entry_t       r_table [ENTRIES];
    logic [ENTRIES-1:0] r_valid;

    btb_state_e       r_state;
    logic [IDX_W-1:0] r_ptr;
    logic             r_busy;

    logic             r_pred_valid;
    logic             r_pred_taken;
    logic [31:0]      r_pred_target;

    logic [IDX_W-1:0]     w_fetch_idx, w_upd_idx;
    logic [TAG_W-1:0]     w_fetch_tag_raw, w_upd_tag_raw;
    logic [BTB_TAG_W-1:0] w_fetch_tag, w_upd_tag;
    btb_entry_t           w_fetch_entry, w_upd_entry, w_wr_entry;
    logic                 w_fetch_hit, w_upd_hit, w_upd_en, w_wr_en;
    logic [BTB_CTR_W-1:0] w_ctr_next;
    logic                 w_unused;

    assign w_fetch_idx     = fetch_pc_i[IDX_W+1:2];
    assign w_fetch_tag_raw = fetch_pc_i[31:IDX_W+2];
    assign w_fetch_tag     = BTB_TAG_W'(w_fetch_tag_raw);
    assign w_upd_idx       = upd_pc_i[IDX_W+1:2];
    assign w_upd_tag_raw   = upd_pc_i[31:IDX_W+2];
    assign w_upd_tag       = BTB_TAG_W'(w_upd_tag_raw);
    assign w_unused        = ^{fetch_pc_i[1:0], upd_pc_i[1:0], upd_target_i[0]};

    // Read both ports, substituting the live valid bit
    always_comb begin
        w_fetch_entry       = r_table[w_fetch_idx];
        w_fetch_entry.valid = r_valid[w_fetch_idx];
        w_upd_entry         = r_table[w_upd_idx];
        w_upd_entry.valid   = r_valid[w_upd_idx];
    end

    // Lookups are suppressed while sweeping and in the cycle that starts one
    assign w_fetch_hit = fetch_req_i && (r_state == BTB_IDLE) && !flush_i &&
                         w_fetch_entry.valid && (w_fetch_entry.tag == w_fetch_tag);
    assign w_upd_hit   = w_upd_entry.valid && (w_upd_entry.tag == w_upd_tag);
    assign w_upd_en    = upd_valid_i && (r_state == BTB_IDLE);

    btb_sat_counter u_ctr (
        .i_ctr   (w_upd_entry.ctr),
        .i_taken (upd_taken_i),
        .o_ctr   (w_ctr_next)
    );

    // Decide whether and what the resolved instruction writes
    always_comb begin
        w_wr_en    = 1'b0;
        w_wr_entry = w_upd_entry;
        if (w_upd_en) begin
            if (upd_opcode_i == OPCODE_JUMP || upd_opcode_i == OPCODE_JUMP_R) begin
                w_wr_en    = 1'b1;
                w_wr_entry = '{valid: 1'b1, tag: w_upd_tag,
                               target: upd_target_i[31:1], ctr: BTB_CTR_JUMP};
            end else if (upd_opcode_i == OPCODE_BRANCH) begin
                if (w_upd_hit) begin
                    w_wr_en        = 1'b1;
                    w_wr_entry.ctr = w_ctr_next;
                    if (upd_taken_i) w_wr_entry.target = upd_target_i[31:1];
                end else if (upd_taken_i) begin
                    w_wr_en    = 1'b1;
                    w_wr_entry = '{valid: 1'b1, tag: w_upd_tag,
                                   target: upd_target_i[31:1], ctr: BTB_CTR_ALLOC};
                end
            end
        end
    end

    // Data array write port (no reset: valid bits guard stale contents)
    always_ff @(posedge clk_i) begin
        if (w_wr_en) r_table[w_upd_idx] <= w_wr_entry;
    end

    // Registered prediction; taken/target only change on a hit
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pred_valid  <= 1'b0;
            r_pred_taken  <= 1'b0;
            r_pred_target <= '0;
        end else begin
            r_pred_valid <= w_fetch_hit;
            if (w_fetch_hit) begin
                r_pred_taken  <= w_fetch_entry.ctr[BTB_CTR_W-1];
                r_pred_target <= {w_fetch_entry.target, 1'b0};
            end
        end
    end

    // Sweep FSM, also owner of the valid bits
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= BTB_IDLE;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
            r_valid <= '0;
        end else begin
            case (r_state)
                BTB_IDLE: begin
                    if (w_wr_en) r_valid[w_upd_idx] <= 1'b1;
                    if (flush_i) begin
                        r_state <= BTB_SWEEP;
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                BTB_SWEEP: begin
                    r_valid[r_ptr] <= 1'b0;
                    r_ptr          <= r_ptr + 1'b1;
                    if (r_ptr == LAST_IDX) begin
                        r_state <= BTB_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= BTB_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign pred_valid_o  = r_pred_valid;
    assign pred_taken_o  = r_pred_taken;
    assign pred_target_o = r_pred_target;
    assign busy_o        = r_busy;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer against a per-index
// behavioural model. Honours BTB_HYST_EN like the design.
module tb_branch_target_buffer;
    import core_pkg::*;

    localparam int N = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fetch_req = 1'b0;
    logic [31:0]   fetch_pc = '0;
    logic          pred_valid, pred_taken;
    logic [31:0]   pred_target;
    logic          upd_valid = 1'b0;
    logic [31:0]   upd_pc = '0, upd_target = '0;
    logic          upd_taken = 1'b0;
    rv32_opcodes_e upd_opcode = OPCODE_OP;
    logic          flush = 1'b0;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    branch_target_buffer #(.ENTRIES(N)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .fetch_req_i(fetch_req), .fetch_pc_i(fetch_pc),
        .pred_valid_o(pred_valid), .pred_taken_o(pred_taken), .pred_target_o(pred_target),
        .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_target_i(upd_target),
        .upd_taken_i(upd_taken), .upd_opcode_i(upd_opcode),
        .flush_i(flush), .busy_o(busy)
    );

    // ---------------- reference model ----------------
    bit          m_valid  [N];
    logic [31:0] m_tag    [N];
    logic [31:0] m_target [N];
    int          m_ctr    [N];
    int          m_sweep_left;

    function automatic int idx_of(logic [31:0] pc);
        return int'((pc / 4) % N);
    endfunction

    function automatic logic [31:0] tag_of(logic [31:0] pc);
        return pc / (4 * N);
    endfunction

    function automatic bit ctr_says_taken(int c);
`ifdef BTB_HYST_EN
        return c >= 2;
`else
        return c == 1;
`endif
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_valid[i] = 0;
        m_sweep_left = 0;
    endtask

    task automatic model_update(logic [31:0] pc, logic [31:0] tgt, logic tk, rv32_opcodes_e op);
        int  i;
        bit  hit;
        i   = idx_of(pc);
        hit = m_valid[i] && (m_tag[i] == tag_of(pc));
        if (op == OPCODE_JUMP || op == OPCODE_JUMP_R) begin
            m_valid[i] = 1; m_tag[i] = tag_of(pc); m_target[i] = tgt & ~32'd1;
`ifdef BTB_HYST_EN
            m_ctr[i] = 3;
`else
            m_ctr[i] = 1;
`endif
        end else if (op == OPCODE_BRANCH) begin
            if (hit) begin
`ifdef BTB_HYST_EN
                if (tk) m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                else    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
`else
                m_ctr[i] = tk ? 1 : 0;
`endif
                if (tk) m_target[i] = tgt & ~32'd1;
            end else if (tk) begin
                m_valid[i] = 1; m_tag[i] = tag_of(pc); m_target[i] = tgt & ~32'd1;
`ifdef BTB_HYST_EN
                m_ctr[i] = 2;
`else
                m_ctr[i] = 1;
`endif
            end
        end
    endtask

    // One clock: drive at negedge, predict from model, check at next negedge
    task automatic step(input logic req, input logic [31:0] fpc,
                        input logic upd, input logic [31:0] upc, input logic [31:0] utgt,
                        input logic utk, input rv32_opcodes_e uop,
                        input logic fl, input string name);
        bit sweeping, e_valid, e_taken, e_busy;
        logic [31:0] e_target;
        int i;
        fetch_req = req; fetch_pc = fpc;
        upd_valid = upd; upd_pc = upc; upd_target = utgt; upd_taken = utk; upd_opcode = uop;
        flush = fl;
        sweeping = (m_sweep_left > 0);
        e_valid = 0; e_taken = 0; e_target = '0;
        if (req && !sweeping && !fl) begin
            i = idx_of(fpc);
            if (m_valid[i] && m_tag[i] == tag_of(fpc)) begin
                e_valid = 1; e_taken = ctr_says_taken(m_ctr[i]); e_target = m_target[i];
            end
        end
        if (sweeping) m_sweep_left--;
        else begin
            if (upd) model_update(upc, utgt, utk, uop);
            if (fl) begin
                model_clear();
                m_sweep_left = N;
            end
        end
        e_busy = (m_sweep_left > 0);
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (pred_valid !== e_valid) begin
            n_fail++;
            $display("FAIL %s.valid pc=%h: got %b expected %b", name, fpc, pred_valid, e_valid);
        end
        n_tests++;
        if (busy !== e_busy) begin
            n_fail++;
            $display("FAIL %s.busy: got %b expected %b", name, busy, e_busy);
        end
        if (e_valid) begin
            n_tests++;
            if (pred_taken !== e_taken) begin
                n_fail++;
                $display("FAIL %s.taken pc=%h: got %b expected %b", name, fpc, pred_taken, e_taken);
            end
            n_tests++;
            if (pred_target !== e_target) begin
                n_fail++;
                $display("FAIL %s.target pc=%h: got %h expected %h", name, fpc, pred_target, e_target);
            end
        end
    endtask

    task automatic look(input logic [31:0] pc, input string name);
        step(1'b1, pc, 1'b0, '0, '0, 1'b0, OPCODE_OP, 1'b0, name);
    endtask

    task automatic update(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                          input rv32_opcodes_e op, input string name);
        step(1'b0, '0, 1'b1, pc, tgt, tk, op, 1'b0, name);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        fetch_req = 0; upd_valid = 0; flush = 0;
        model_clear();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        n_tests++;
        if ({pred_valid, pred_taken, busy} !== 3'b000 || pred_target !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b t=%b b=%b tgt=%h expected all 0",
                     pred_valid, pred_taken, busy, pred_target);
        end
        look(32'h100, "reset_lookup");
        n_tests++;
        if (pred_target !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_target: got %h expected 00000000", pred_target);
        end
    endtask

    task automatic test_jump();
        update(32'h100, 32'h2000, 1'b1, OPCODE_JUMP, "jump_upd");
        look(32'h100, "jump_hit");
        n_tests++;
        if (pred_target !== 32'h2000) begin
            n_fail++;
            $display("FAIL jump_target_const: got %h expected 00002000", pred_target);
        end
        look(32'h180, "jump_alias_miss");
        update(32'h104, 32'h3001, 1'b0, OPCODE_JUMP_R, "jalr_upd");
        look(32'h104, "jalr_hit");
        step(1'b0, 32'h100, 1'b0, '0, '0, 1'b0, OPCODE_OP, 1'b0, "no_req");
    endtask

    task automatic test_branch_ctr();
        update(32'h40, 32'h800, 1'b1, OPCODE_BRANCH, "br_alloc");
        look(32'h40, "br_after_t");
        update(32'h40, 32'h900, 1'b0, OPCODE_BRANCH, "br_nt1");
        look(32'h40, "br_after_n");
        update(32'h40, 32'h900, 1'b0, OPCODE_BRANCH, "br_nt2");
        look(32'h40, "br_after_nn");
        update(32'h40, 32'h900, 1'b0, OPCODE_BRANCH, "br_nt3");
        look(32'h40, "br_sat_low");
        for (int k = 0; k < 4; k++) update(32'h40, 32'hA00 + k * 4, 1'b1, OPCODE_BRANCH, "br_up");
        look(32'h40, "br_sat_high");
        update(32'h40, 32'hB00, 1'b1, OPCODE_OP, "other_op");
        look(32'h40, "other_op_ignored");
    endtask

    task automatic test_nt_miss();
        update(32'h80, 32'h1000, 1'b0, OPCODE_BRANCH, "nt_miss_upd");
        look(32'h80, "nt_miss_lookup");
    endtask

    task automatic test_same_cycle();
        apply_reset();
        step(1'b1, 32'h300, 1'b1, 32'h300, 32'h4444, 1'b1, OPCODE_JUMP, 1'b0, "rbw_same");
        look(32'h300, "rbw_next");
    endtask

    task automatic test_flush();
        int busy_cycles;
        for (int k = 0; k < 4; k++)
            update(32'h400 + k * 4, 32'h5000 + k * 16, 1'b1, OPCODE_JUMP, "fill");
        for (int k = 0; k < 4; k++) look(32'h400 + k * 4, "fill_hit");
        step(1'b1, 32'h400, 1'b0, '0, '0, 1'b0, OPCODE_OP, 1'b1, "flush_start");
        busy_cycles = busy ? 1 : 0;
        for (int j = 0; j < 40; j++) begin
            if (j == 5)
                step(1'b1, 32'h404, 1'b0, '0, '0, 1'b0, OPCODE_OP, 1'b1, "reflush");
            else if (j == 10)
                step(1'b1, 32'h408, 1'b1, 32'h500, 32'h6000, 1'b1, OPCODE_JUMP, 1'b0, "sweep_upd");
            else
                look(32'h400 + (j % 4) * 4, "sweep_look");
            if (busy) busy_cycles++;
        end
        n_tests++;
        if (busy_cycles != N) begin
            n_fail++;
            $display("FAIL busy_length: got %0d expected %0d", busy_cycles, N);
        end
        for (int k = 0; k < 4; k++) look(32'h400 + k * 4, "post_flush");
        look(32'h500, "dropped_upd");
    endtask

    task automatic test_reset_mid_sweep();
        update(32'h600, 32'h7000, 1'b1, OPCODE_JUMP, "pre_rst_fill");
        step(1'b0, '0, 1'b0, '0, '0, 1'b0, OPCODE_OP, 1'b1, "rst_flush");
        for (int j = 0; j < 5; j++) look(32'h600, "rst_sweep");
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || pred_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got busy=%b valid=%b expected 0 0", busy, pred_valid);
        end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        look(32'h600, "post_rst");
        update(32'h600, 32'h7100, 1'b1, OPCODE_JUMP, "post_rst_upd");
        look(32'h600, "post_rst_hit");
    endtask

    task automatic test_random();
        logic [31:0] pool [8];
        rv32_opcodes_e ops [4];
        pool[0] = 32'h40;   pool[1] = 32'h44;   pool[2] = 32'hC0;   pool[3] = 32'h1040;
        pool[4] = 32'h2040; pool[5] = 32'h3C;   pool[6] = 32'h8000_0044; pool[7] = 32'hC4;
        ops[0] = OPCODE_BRANCH; ops[1] = OPCODE_JUMP; ops[2] = OPCODE_JUMP_R; ops[3] = OPCODE_OP;
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 3) != 0), pool[$urandom_range(0, 7)],
                 1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], $urandom,
                 1'($urandom_range(0, 1)), ops[($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 3)],
                 1'($urandom_range(0, 199) == 0), "random");
        end
        while (m_sweep_left > 0) look(pool[0], "random_drain");
    endtask

    initial begin
        model_clear();
        test_reset();
        test_jump();
        test_branch_ctr();
        test_nt_miss();
        test_same_cycle();
        test_flush();
        test_reset_mid_sweep();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Fetch-side predictor; the consumer of the jump/branch targets that execute resolves.
- Direct-mapped table indexed by PC. Written by execute with each resolved target, taken/not-taken outcome and opcode.
- Read every fetch cycle; supplies a predicted next-PC one cycle later.
- Includes an invalidate sweep FSM for fence.i/context flush.

Parameters:
- ENTRIES, 32, table depth; power of two, 4..256.
- IDX_W, $clog2(ENTRIES), index width; derived, not overridden.
- TAG_W, 30-IDX_W, tag width = pc[31:IDX_W+2].

Ports:
- clk_i  in  1  core clock.
- rst_ni  in  1  reset; one clock, asynchronous, active-low.
- fetch_req_i  in  1  lookup request this cycle.
- fetch_pc_i  in  32  PC being fetched; bits [1:0] ignored.
- pred_valid_o  out  1  registered lookup hit for the previous-cycle request.
- pred_taken_o  out  1  predicted taken (valid only with pred_valid_o).
- pred_target_o  out  32  predicted target, bit0 = 0.
- upd_valid_i  in  1  resolved control-flow instruction from execute.
- upd_pc_i  in  32  PC of the resolved instruction.
- upd_target_i  in  32  resolved target address.
- upd_taken_i  in  1  resolved outcome.
- upd_opcode_i  in  rv32_opcodes_e  BRANCH, JUMP or JUMP_R; others ignored.
- flush_i  in  1  start invalidate sweep (pulse).
- busy_o  out  1  sweep in progress.

Behaviour:
- Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]. Entry = {valid, tag, target[31:1], ctr}.
- Reset: all valid bits cleared; pred_valid_o=0, pred_taken_o=0, pred_target_o=0, busy_o=0; FSM in IDLE.
- Lookup latency:
  - fetch_req_i with fetch_pc_i in cycle N → outputs in cycle N+1.
  - pred_valid_o = entry valid and tag match.
  - pred_taken_o = ctr[MSB].
  - pred_target_o = {target, 1'b0}.
  - fetch_req_i=0 → pred_valid_o=0 next cycle; the target register holds its value.
- Update, applied at clock edge when upd_valid_i and FSM IDLE:
  - JUMP/JUMP_R: write tag and target, set valid, ctr = strongly-taken (2'b11).
  - BRANCH, hit: saturating ctr ±1 by upd_taken_i; target overwritten only if taken.
  - BRANCH, miss, taken: allocate (replacing any occupant), ctr = weakly-taken (2'b10).
  - BRANCH, miss, not taken: no write.
  - Other opcodes: no write.
- Same-index lookup and update in the same cycle: the lookup returns pre-update contents (read-before-write).
- FSM states:
  - IDLE → SWEEP on flush_i. Sweep pointer = 0, busy_o=1 from the next cycle.
  - SWEEP clears valid[ptr] each cycle, ptr+1. At ptr = ENTRIES-1, clear that entry and return to IDLE; busy_o=0 the following cycle.
  - Sweep takes exactly ENTRIES cycles.
- During SWEEP: pred_valid_o forced 0, upd_valid_i ignored, flush_i ignored (no restart).
- Async reset mid-sweep: immediately IDLE, all valid cleared.
- Counter saturates at 2'b00 and 2'b11; no wrap.

Optional Feature:
- BTB_HYST_EN defined: ctr is a 2-bit saturating counter, as above.
- Not defined: ctr is 1 bit.
  - BRANCH hit: ctr = upd_taken_i.
  - Allocation, and JUMP/JUMP_R writes: ctr = 1.
  - pred_taken_o = ctr.
- Port list is identical either way.

Decomposition:
- core_pkg gains btb_entry_t (packed valid/tag/target/ctr, sized by BTB_TAG_W/BTB_IDX_W localparams), btb_state_e {BTB_IDLE, BTB_SWEEP} and the counter constants CTR_WEAK_T=2'b10, CTR_STRONG_T=2'b11.
- rv32_opcodes_e is reused from core_pkg.
- One sub-module: btb_sat_counter. Combinational next-counter from {ctr, taken}, width selected by BTB_HYST_EN.

Test Plan:
- Reset, then lookup pc=0x100 → next cycle pred_valid_o=0, pred_target_o=0.
- Update JUMP pc=0x100 target=0x2000, then lookup 0x100 → pred_valid_o=1, pred_taken_o=1, pred_target_o=0x2000. Lookup 0x180 (same index, ENTRIES=32, different tag) → pred_valid_o=0.
- BRANCH pc=0x40, sequence taken, not-taken, not-taken with BTB_HYST_EN:
  - after first (allocation): ctr=10, pred_taken_o=1;
  - after second: ctr=01, pred_taken_o=0;
  - after third: ctr=00, still hit.
  - Without the macro: taken after the first update, not-taken after the second.
- BRANCH not-taken miss pc=0x80 → later lookup 0x80 gives pred_valid_o=0.
- Same-cycle update JUMP pc=0x300 and lookup 0x300 on an empty table → pred_valid_o=0; repeat the lookup next cycle → hit.
- Fill 4 entries, pulse flush_i:
  - busy_o high for exactly 32 cycles;
  - an update issued mid-sweep is dropped;
  - all lookups afterwards miss.
  - Assert rst_ni low mid-sweep → busy_o=0 immediately.
